// File: rtl/conv_frame_ctrl.sv
// Sequencer for a 3x3 convolution over one IMG_W x IMG_H frame held in single-port pixel SRAM.
// Optional build macro CONV_WGT_KEEP_EN adds i_keep_wgt to start a frame on previously loaded weights.
module conv_frame_ctrl #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
`ifdef CONV_WGT_KEEP_EN
  input  logic                     i_keep_wgt,
`endif
  input  logic                     i_wgt_valid,
  input  logic [7:0]               i_wgt_data,
  output logic                     o_wgt_ready,
  output logic                     o_mem_ren,
  output logic [ADDR_W-1:0]        o_mem_addr,
  input  logic [7:0]               i_mem_rdata,
  output logic [71:0]              o_win_pix,
  output logic [71:0]              o_win_wgt,
  input  logic [7:0]               i_conv_result,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [7:0]               o_out_data,
  output logic [$clog2(IMG_W)-1:0] o_out_x,
  output logic [$clog2(IMG_H)-1:0] o_out_y,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StFetch, StCap, StEmit, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q;
  logic [3:0]      k_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [7:0]      win_q [9];
  logic [7:0]      wgt_q [9];
  // Tap issued last cycle; its read data lands this cycle.
  logic            pend_q;
  logic [3:0]      pend_slot_q;
  logic            pend_inb_q;

  logic [1:0]        kx, ky;
  logic              tap_inb;
  logic [ADDR_W-1:0] tap_addr;
  logic              last_pix;
  logic              reuse_wgt;

`ifdef CONV_WGT_KEEP_EN
  logic wgt_loaded_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wgt_loaded_q <= 1'b0;
    end else if (state_q == StLoadW && i_wgt_valid && wcnt_q == 4'd8) begin
      wgt_loaded_q <= 1'b1;
    end
  end

  assign reuse_wgt = i_keep_wgt & wgt_loaded_q;
`else
  assign reuse_wgt = 1'b0;
`endif

  always_comb begin
    kx      = 2'(k_q % 4'd3);
    ky      = 2'(k_q / 4'd3);
    tap_inb = 1'b1;
    if (kx == 2'd0 && x_q == '0)    tap_inb = 1'b0;
    if (kx == 2'd2 && x_q == XLast) tap_inb = 1'b0;
    if (ky == 2'd0 && y_q == '0)    tap_inb = 1'b0;
    if (ky == 2'd2 && y_q == YLast) tap_inb = 1'b0;
    // Negative intermediates only arise for out-of-bounds taps, whose address is discarded.
    tap_addr = ADDR_W'((int'(y_q) + int'(ky) - 1) * int'(IMG_W) + int'(x_q) + int'(kx) - 1);
  end

  assign last_pix = (x_q == XLast) && (y_q == YLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_wgt_ready = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_addr  = '0;
    o_out_valid = 1'b0;
    o_done      = 1'b0;
    o_busy      = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (i_start) state_d = reuse_wgt ? StFetch : StLoadW;
      end
      StLoadW: begin
        o_wgt_ready = 1'b1;
        if (i_wgt_valid && wcnt_q == 4'd8) state_d = StFetch;
      end
      StFetch: begin
        o_mem_ren  = tap_inb;
        o_mem_addr = tap_inb ? tap_addr : '0;
        if (k_q == 4'd8) state_d = StCap;
      end
      StCap: begin
        state_d = StEmit;
      end
      StEmit: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_d = last_pix ? StDone : StFetch;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt_q      <= '0;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      pend_inb_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
        wgt_q[i] <= '0;
      end
    end else begin
      pend_q <= 1'b0;
      if (pend_q) win_q[pend_slot_q] <= pend_inb_q ? i_mem_rdata : 8'h00;

      if (state_q == StIdle && i_start) begin
        x_q <= '0;
        y_q <= '0;
        k_q <= '0;
      end

      if (state_q == StLoadW && i_wgt_valid) begin
        wgt_q[wcnt_q] <= i_wgt_data;
        wcnt_q        <= (wcnt_q == 4'd8) ? 4'd0 : wcnt_q + 4'd1;
      end

      if (state_q == StFetch) begin
        pend_q      <= 1'b1;
        pend_slot_q <= k_q;
        pend_inb_q  <= tap_inb;
        k_q         <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
      end

      if (state_q == StEmit && i_out_ready) begin
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= last_pix ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_win_pix = '0;
    o_win_wgt = '0;
    for (int i = 0; i < 9; i++) begin
      o_win_pix[71-8*i -: 8] = win_q[i];
      o_win_wgt[71-8*i -: 8] = wgt_q[i];
    end
  end

  assign o_out_data = i_conv_result;
  assign o_out_x    = x_q;
  assign o_out_y    = y_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: SRAM and conv_3x3 models plus a frame-level reference computed from the image.
module tb_conv_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          wgt_valid = 1'b0;
  logic [7:0]    wgt_data = 8'h00;
  logic          wgt_ready;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [71:0]   win_pix, win_wgt;
  logic [7:0]    conv_res;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [2:0]    out_x, out_y;
  logic          busy, done;
`ifdef CONV_WGT_KEEP_EN
  logic          keep_wgt = 1'b0;
`endif

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [7:0] img [W*H];
  logic [7:0] wts [9];

  always #5 clk = ~clk;

  // Reads return garbage when not enabled so missing zero padding is visible.
  always @(posedge clk) begin
    mem_rdata <= mem_ren ? img[mem_addr] : 8'($urandom);
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [7:0] clamp8(input int acc);
    int s;
    s = acc >>> 7;
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hff;
    return 8'(s);
  endfunction

  function automatic logic [7:0] conv(input logic [71:0] p, input logic [71:0] w);
    int acc;
    acc = 0;
    for (int i = 0; i < 9; i++)
      acc += int'($signed(w[71-8*i -: 8])) * int'(p[71-8*i -: 8]);
    return clamp8(acc);
  endfunction

  always_comb conv_res = conv(win_pix, win_wgt);

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
`ifdef CONV_WGT_KEEP_EN
    .i_keep_wgt    (keep_wgt),
`endif
    .i_wgt_valid   (wgt_valid),
    .i_wgt_data    (wgt_data),
    .o_wgt_ready   (wgt_ready),
    .o_mem_ren     (mem_ren),
    .o_mem_addr    (mem_addr),
    .i_mem_rdata   (mem_rdata),
    .o_win_pix     (win_pix),
    .o_win_wgt     (win_wgt),
    .i_conv_result (conv_res),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_out_x       (out_x),
    .o_out_y       (out_y),
    .o_busy        (busy),
    .o_done        (done)
  );

  function automatic bit inb(input int nx, input int ny);
    return nx >= 0 && nx < W && ny >= 0 && ny < H;
  endfunction

  function automatic logic [71:0] ref_win(input int x, input int y);
    logic [71:0] r;
    int nx, ny;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      nx = x + k % 3 - 1;
      ny = y + k / 3 - 1;
      if (inb(nx, ny)) r[71-8*k -: 8] = img[ny*W+nx];
    end
    return r;
  endfunction

  function automatic logic [71:0] ref_wgt();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[71-8*k -: 8] = wts[k];
    return r;
  endfunction

  function automatic logic [7:0] ref_pix(input int x, input int y);
    int acc, nx, ny;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      nx = x + k % 3 - 1;
      ny = y + k / 3 - 1;
      if (inb(nx, ny)) acc += int'($signed(wts[k])) * int'(img[ny*W+nx]);
    end
    return clamp8(acc);
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ctl"}, {busy, wgt_ready, mem_ren, out_valid, done}, 72'd0);
    chk({tag, "_win"}, win_pix, 72'd0);
    chk({tag, "_wgt"}, win_wgt, 72'd0);
    chk({tag, "_pos"}, {out_x, out_y, mem_addr, out_data}, 72'd0);
  endtask

  // rnd_ready: random stalls, else ready held 1 except a 5-cycle stall at (3,2).
  task automatic run_frame(input bit rnd_ready, input int abort_idx, input bit keep);
    int since, pix, guard, stall, d0, x, y, exp_n, nx, ny;
    bit in_emit, aborted, ok, hs;
    logic [AW-1:0] rd_q [$];
    logic [71:0] snap_win;
    logic [13:0] snap_misc;
    d0 = done_cnt;
    start = 1'b1;
`ifdef CONV_WGT_KEEP_EN
    keep_wgt = keep;
`endif
    step();
    start = 1'b0;
`ifdef CONV_WGT_KEEP_EN
    keep_wgt = 1'b0;
    if (keep) chk("keep_direct_fetch", {wgt_ready, busy}, 72'b01);
`endif
    if (!keep) begin
      chk("wgt_ready", {wgt_ready, busy}, 72'b11);
      for (int i = 0; i < 9; i++) begin
        wgt_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        wgt_valid = 1'b1;
        wgt_data  = wts[i];
        step();
      end
      wgt_valid = 1'b0;
    end
    since = 0; pix = 0; guard = 0; stall = 0; in_emit = 0; aborted = 0;
    while (pix < W * H && !aborted && guard < 3000) begin
      guard++;
      if (mem_ren) rd_q.push_back(mem_addr);
      if (pix == abort_idx && since == 3) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        aborted = 1;
        chk_idle_zero("abort");
      end else begin
        if (out_valid && !in_emit) begin
          x = pix % W;
          y = pix / W;
          in_emit   = 1;
          snap_win  = win_pix;
          snap_misc = {out_data, out_x, out_y};
          chk("latency", since, 10);
          chk("pos", {out_x, out_y}, {3'(x), 3'(y)});
          chk("window", win_pix, ref_win(x, y));
          chk("weights", win_wgt, ref_wgt());
          chk("data", out_data, ref_pix(x, y));
          exp_n = 0;
          ok    = 1;
          for (int k = 0; k < 9; k++) begin
            nx = x + k % 3 - 1;
            ny = y + k / 3 - 1;
            if (inb(nx, ny)) begin
              if (exp_n >= rd_q.size() || rd_q[exp_n] != AW'(ny * W + nx)) ok = 0;
              exp_n++;
            end
          end
          chk("rd_count", rd_q.size(), exp_n);
          chk("rd_addrs", ok, 1);
          rd_q.delete();
          if (rnd_ready) stall = $urandom_range(0, 3);
          else stall = (x == 3 && y == 2) ? 5 : 0;
        end else if (out_valid) begin
          chk("hold", {out_data, out_x, out_y, mem_ren}, {snap_misc, 1'b0});
          chk("hold_win", win_pix, snap_win);
        end
        out_ready = (stall == 0);
        if (out_valid && stall > 0) stall--;
        hs = out_valid && out_ready;
        step();
        since++;
        if (hs) begin
          since   = 0;
          pix++;
          in_emit = 0;
        end
      end
    end
    if (aborted) begin
      chk("abort_no_done", done_cnt - d0, 0);
    end else begin
      chk("frame_outputs", pix, W * H);
      chk("done_pulse", {done, busy}, 72'b11);
      step();
      chk("idle_after", {done, busy}, 72'b00);
      chk("done_once", done_cnt - d0, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();

    // Box kernel over a flat frame: corners 32, edges 48, interior 72.
    for (int i = 0; i < W * H; i++) img[i] = 8'd64;
    for (int k = 0; k < 9; k++) wts[k] = 8'h10;
    run_frame(1'b0, -1, 1'b0);

    // Random frame aborted by reset during FETCH of pixel (5,4).
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    for (int k = 0; k < 9; k++) wts[k] = 8'($urandom_range(0, 80)) - 8'd32;
    run_frame(1'b1, 4 * W + 5, 1'b0);

    // Full frame after the abort, with freshly loaded weights.
    for (int k = 0; k < 9; k++) wts[k] = 8'($urandom_range(0, 80)) - 8'd32;
    run_frame(1'b1, -1, 1'b0);

`ifdef CONV_WGT_KEEP_EN
    run_frame(1'b1, -1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    keep_wgt = 1'b1;
    step();
    start = 1'b0;
    keep_wgt = 1'b0;
    chk("keep_after_reset_loads", wgt_ready, 72'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
